spi_master_tx: RTL and testbench

SPI master (initiator) for single-byte transfers in mode 0 (CPOL=0, CPHA=0), MSB first. It generates SCLK and an active-low CS from the system clock, shifts a byte out on MOSI and captures a byte from MISO. It is the driving end for the team's on-chip SPI slave receivers, which oversample SCLK, CS and MOSI on the same system clock. A simple valid/ready handshake feeds it, and it reports completion with a one-cycle received-byte strobe.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_half_bit_timer.sv | 31 +++
 rtl/spi_master_tx.sv | 137 +++++++++++++
 tb/tb_spi_master_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM states and mode-0 framing constants.
package spi_pkg;

    localparam int SPI_CPOL         = 0;
    localparam int SPI_CPHA         = 0;
    localparam int SPI_BYTE_W       = 8;
    // 8 high phases interleaved with 7 inter-bit low phases
    localparam int SPI_SHIFT_HALVES = 2 * SPI_BYTE_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        INACTIVE
    } spi_state_t;

endpackage

// File: rtl/spi_half_bit_timer.sv
// Half-period divider: counts 0..H-1 while enabled and strobes on the last cycle.
module spi_half_bit_timer #(
    parameter int  H  = 4,
    localparam int CW = (H > 1) ? $clog2(H) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    input  logic          i_clear,
    output logic          o_phase_end,
    output logic [CW-1:0] o_half_cnt
);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last      = (r_cnt == CW'(H - 1));
    assign o_phase_end = i_enable && w_last;
    assign o_half_cnt  = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// Mode-0, MSB-first single-byte SPI master with valid/ready request and rx strobe.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int CS_INACTIVE_CLKS  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tx_dv,
    input  logic [SPI_BYTE_W-1:0] i_tx_byte,
    output logic                  o_tx_ready,
    output logic                  o_rx_dv,
    output logic [SPI_BYTE_W-1:0] o_rx_byte,
    output logic                  o_sclk,
    output logic                  o_cs_n,
    output logic                  o_mosi,
    input  logic                  i_miso
);

    localparam int CW = $clog2(CLKS_PER_HALF_BIT);
    localparam int IW = $clog2(CS_INACTIVE_CLKS + 1);

    generate
        if (CLKS_PER_HALF_BIT < 2) begin : g_bad_half_bit
            $error("spi_master_tx: CLKS_PER_HALF_BIT must be >= 2");
        end
        if (CS_INACTIVE_CLKS < 1) begin : g_bad_inactive
            $error("spi_master_tx: CS_INACTIVE_CLKS must be >= 1");
        end
    endgenerate

    spi_state_t            r_state, w_state_nxt;
    logic [3:0]            r_half, w_half_nxt;
    logic [IW-1:0]         r_inact;
    logic [SPI_BYTE_W-1:0] r_tx_sr, r_rx_sr, r_rx_byte;
    logic                  r_tx_ready, r_rx_dv, r_sclk, r_cs_n, r_mosi;
    logic                  w_accept, w_in_frame, w_nxt_in_frame;
    logic                  w_phase_end, w_fall, w_sample;
    logic [CW-1:0]         w_div_cnt;

    assign w_accept       = i_tx_dv && r_tx_ready;
    assign w_in_frame     = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
    assign w_nxt_in_frame = (w_state_nxt == SETUP) || (w_state_nxt == SHIFT) ||
                            (w_state_nxt == HOLD);
    // Even half-periods are SCLK-high; their end is the falling edge
    assign w_fall         = (r_state == SHIFT) && w_phase_end && !r_half[0];
    assign w_sample       = (r_state == SHIFT) && !r_half[0] &&
                            (w_div_cnt == CW'(CLKS_PER_HALF_BIT - 1));

    spi_half_bit_timer #(
        .H (CLKS_PER_HALF_BIT)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_enable    (w_in_frame),
        .i_clear     (!w_in_frame),
        .o_phase_end (w_phase_end),
        .o_half_cnt  (w_div_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_half  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_half  <= w_half_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = SETUP;
            end
            SETUP: begin
                if (w_phase_end) begin
                    w_state_nxt = SHIFT;
                    w_half_nxt  = '0;
                end
            end
            SHIFT: begin
                if (w_phase_end) begin
                    if (r_half == 4'(SPI_SHIFT_HALVES - 1)) w_state_nxt = HOLD;
                    else                                    w_half_nxt  = r_half + 1'b1;
                end
            end
            HOLD: begin
                if (w_phase_end) w_state_nxt = INACTIVE;
            end
            INACTIVE: begin
                if (r_inact == IW'(CS_INACTIVE_CLKS - 1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pin-facing outputs are registered from the next state so SCLK/CS never glitch
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inact    <= '0;
            r_tx_ready <= 1'b1;
            r_rx_dv    <= 1'b0;
            r_rx_byte  <= '0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_inact    <= (r_state == INACTIVE) ? r_inact + 1'b1 : '0;
            r_tx_ready <= (w_state_nxt == IDLE);
            r_cs_n     <= !w_nxt_in_frame;
            r_sclk     <= (w_state_nxt == SHIFT) && !w_half_nxt[0];
            r_rx_dv    <= (r_state == HOLD) && (w_state_nxt == INACTIVE);
            if ((r_state == HOLD) && (w_state_nxt == INACTIVE)) r_rx_byte <= r_rx_sr;
            if (w_accept)    r_mosi <= i_tx_byte[SPI_BYTE_W-1];
            else if (w_fall) r_mosi <= r_tx_sr[SPI_BYTE_W-1];
        end
    end

    // Shift registers carry data only; a zero fills in so MOSI ends low
    always_ff @(posedge i_clk) begin
        if (w_accept)    r_tx_sr <= {i_tx_byte[SPI_BYTE_W-2:0], 1'b0};
        else if (w_fall) r_tx_sr <= {r_tx_sr[SPI_BYTE_W-2:0], 1'b0};
        if (w_sample)    r_rx_sr <= {r_rx_sr[SPI_BYTE_W-2:0], i_miso};
    end

    assign o_tx_ready = r_tx_ready;
    assign o_rx_dv    = r_rx_dv;
    assign o_rx_byte  = r_rx_byte;
    assign o_sclk     = r_sclk;
    assign o_cs_n     = r_cs_n;
    assign o_mosi     = r_mosi;

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: stimulus queues expected frames, a monitor checks them.
module tb_spi_master_tx;

    localparam int H = 4;
    localparam int C = 2;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic       clk, i_rst_n, i_tx_dv, i_miso;
    logic [7:0] i_tx_byte;
    logic       o_tx_ready, o_rx_dv, o_sclk, o_cs_n, o_mosi;
    logic [7:0] o_rx_byte;

    exp_t q[$];
    int   n_tests = 0, n_fail = 0;
    int   rises, cs_low, mosi_chg_hi, rdy_hi, hold_ones, mosi_any;
    int   stray_dv = 0, stray_sclk = 0, frames_started = 0, last_gap = 0, hi_run = 0, post = -1;
    logic [7:0] mosi_sr, s_byte;
    logic       miso_loop, prev_cs_n = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic [2:0] sidx;

    spi_master_tx #(
        .CLKS_PER_HALF_BIT (H),
        .CS_INACTIVE_CLKS  (C)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_tx_dv    (i_tx_dv),
        .i_tx_byte  (i_tx_byte),
        .o_tx_ready (o_tx_ready),
        .o_rx_dv    (o_rx_dv),
        .o_rx_byte  (o_rx_byte),
        .o_sclk     (o_sclk),
        .o_cs_n     (o_cs_n),
        .o_mosi     (o_mosi),
        .i_miso     (i_miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mode-0 slave: bit for high phase k is presented once the k-th rising edge is seen
    always_comb begin
        i_miso = 1'b0;
        sidx   = 3'(8 - rises);
        if (miso_loop)                    i_miso = o_mosi;
        else if (rises >= 1 && rises <= 8) i_miso = s_byte[sidx];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_frame();
        rises = 0; cs_low = 0; mosi_chg_hi = 0; rdy_hi = 0; hold_ones = 0;
        mosi_any = 0; mosi_sr = 8'h00;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!i_rst_n) begin
            if (!prev_cs_n) begin
                check("abort_no_rx_dv", 32'(o_rx_dv), 32'd0);
                check("abort_cs_n_high", 32'(o_cs_n), 32'd1);
            end
            clear_frame();
            post = -1;
        end else begin
            if (o_cs_n && o_sclk) stray_sclk++;
            if (!o_cs_n) begin
                if (prev_cs_n) begin
                    frames_started++;
                    last_gap = hi_run;
                    clear_frame();
                end
                cs_low++;
                if (o_sclk && !prev_sclk) begin
                    rises++;
                    mosi_sr = {mosi_sr[6:0], o_mosi};
                end
                if (o_sclk && prev_sclk && (o_mosi != prev_mosi)) mosi_chg_hi++;
                if (rises == 8 && !o_sclk && o_mosi) hold_ones++;
                if (o_mosi) mosi_any = 1;
                if (o_tx_ready) rdy_hi++;
                if (o_rx_dv) stray_dv++;
            end else begin
                if (!prev_cs_n) begin
                    hi_run = 1;
                    post   = 0;
                    check("frame_expected", 32'(q.size() > 0), 32'd1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("cs_low_cycles", 32'(cs_low), 32'(17 * H));
                        check("sclk_rises", 32'(rises), 32'd8);
                        check("mosi_bits", 32'(mosi_sr), 32'(e.tx));
                        check("mosi_any_one", 32'(mosi_any), 32'(e.tx != 8'h00));
                        check("mosi_stable_high", 32'(mosi_chg_hi), 32'd0);
                        check("mosi_zero_hold", 32'(hold_ones), 32'd0);
                        check("ready_low_in_frame", 32'(rdy_hi), 32'd0);
                        check("rx_dv_at_cs_rise", 32'(o_rx_dv), 32'd1);
                        check("rx_byte", 32'(o_rx_byte), 32'(e.rx));
                    end
                end else begin
                    hi_run++;
                    if (o_rx_dv) stray_dv++;
                    if (post >= 0) post++;
                end
                if (post >= 0 && post < C) check("ready_low_before_R+C", 32'(o_tx_ready), 32'd0);
                if (post == C) begin
                    check("ready_high_at_R+C", 32'(o_tx_ready), 32'd1);
                    post = -1;
                end
            end
        end
        prev_cs_n = o_cs_n;
        prev_sclk = o_sclk;
        prev_mosi = o_mosi;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_tx_ready && n < 1000) begin step(); n++; end
        if (!o_tx_ready) check("wait_ready_timeout", 32'(o_tx_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] tx, input logic [7:0] rx);
        wait_ready();
        i_tx_dv   = 1'b1;
        i_tx_byte = tx;
        q.push_back('{tx: tx, rx: rx});
        step();
        i_tx_dv = 1'b0;
    endtask

    task automatic wait_done(input logic [7:0] rx);
        int n = 0;
        while ((q.size() != 0 || !o_tx_ready) && n < 2000) begin step(); n++; end
        check("frame_done_in_time", 32'(q.size() == 0 && o_tx_ready), 32'd1);
        check("rx_byte_held", 32'(o_rx_byte), 32'(rx));
    endtask

    initial begin
        int f, n;
        i_rst_n = 1'b0; i_tx_dv = 1'b0; i_tx_byte = 8'h00; miso_loop = 1'b1; s_byte = 8'h00;
        clear_frame();
        repeat (3) @(posedge clk);
        #1 i_rst_n = 1'b1;
        step();
        check("rst_cs_n", 32'(o_cs_n), 32'd1);
        check("rst_sclk", 32'(o_sclk), 32'd0);
        check("rst_mosi", 32'(o_mosi), 32'd0);
        check("rst_tx_ready", 32'(o_tx_ready), 32'd1);
        check("rst_rx_byte", 32'(o_rx_byte), 32'd0);
        check("rst_rx_dv", 32'(o_rx_dv), 32'd0);

        send(8'hA5, 8'hA5);  wait_done(8'hA5);
        send(8'h3C, 8'h3C);  wait_done(8'h3C);

        miso_loop = 1'b0; s_byte = 8'hC3;
        send(8'h00, 8'hC3);  wait_done(8'hC3);
        miso_loop = 1'b1;

        // Back-to-back with i_tx_dv held; the second byte is whatever is present at its accept
        wait_ready();
        i_tx_dv = 1'b1; i_tx_byte = 8'h01;
        q.push_back('{tx: 8'h01, rx: 8'h01});
        step();
        i_tx_byte = 8'hFF;
        q.push_back('{tx: 8'hFF, rx: 8'hFF});
        n = 0;
        while (!o_tx_ready && n < 2000) begin step(); n++; end
        step();
        i_tx_dv = 1'b0; i_tx_byte = 8'h00;
        wait_done(8'hFF);
        check("b2b_cs_high_gap", 32'(last_gap), 32'(C + 1));

        // Request while busy is dropped
        send(8'h96, 8'h96);
        repeat (20) step();
        f = frames_started;
        i_tx_dv = 1'b1; i_tx_byte = 8'h55;
        step();
        i_tx_dv = 1'b0;
        wait_done(8'h96);
        repeat (40) step();
        check("busy_req_ignored", 32'(frames_started - f), 32'd0);

        // Asynchronous reset during the fourth bit
        send(8'h5A, 8'h5A);
        n = 0;
        while (rises < 4 && n < 500) begin step(); n++; end
        check("reached_bit4", 32'(rises >= 4), 32'd1);
        step();
        i_rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_cs_n", 32'(o_cs_n), 32'd1);
        check("async_rst_sclk", 32'(o_sclk), 32'd0);
        check("async_rst_rx_dv", 32'(o_rx_dv), 32'd0);
        repeat (2) @(posedge clk);
        #1 i_rst_n = 1'b1;
        step();
        send(8'hE7, 8'hE7);  wait_done(8'hE7);

        repeat (10) step();
        check("queue_drained", 32'(q.size()), 32'd0);
        check("rx_dv_single_cycle", 32'(stray_dv), 32'd0);
        check("sclk_only_in_frame", 32'(stray_sclk), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
